pid_datapath: RTL and testbench
===============================

PID_DATAPATH -- requirements
Module: pid_datapath

Interface
REQ-001 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  block enable; low = no new samples accepted.
- sample_valid  in  1  single-cycle strobe: setpoint/feedback valid.
- setpoint  in  8  unsigned target value.
- feedback  in  8  unsigned measured value.
- K_p, K_i, K_d  in  6 each  unsigned gains from the register stage.
- busy  out  1  high while a computation is in flight.
- out_valid  out  1  single-cycle strobe: pid_out updated.
- pid_out  out  8  unsigned saturated controller output.

Function
REQ-002 A sample SHALL be accepted only when sample_valid=1, ena=1 and FSM in IDLE; otherwise the strobe is ignored, with no queuing.
REQ-003 On acceptance K_p, K_i, K_d, setpoint and feedback SHALL be latched; gain changes mid-computation do not affect the result.
REQ-004 FSM states SHALL be IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> OUT -> IDLE, one cycle each, no other transitions.
REQ-005 ERR: e = setpoint - feedback as signed 9-bit; d = e - e_prev as signed 10-bit; integ = sat12(integ + e), with integ signed 12-bit (-2048..2047); e_prev <= e.
REQ-006 MUL_P/MUL_I/MUL_D SHALL add K_p*e, K_i*integ (updated value) and K_d*d into a signed 20-bit accumulator, cleared in ERR; gains are zero-extended.
REQ-007 OUT: pid_out = clamp(acc >>> 4, 0, 255), arithmetic shift; out_valid=1 for exactly this cycle.
REQ-008 Latency from the accepting edge to out_valid SHALL be exactly 5 cycles; max throughput is one sample per 6 cycles.
REQ-009 busy SHALL be 1 in every state except IDLE.
REQ-010 ena falling mid-computation SHALL NOT abort it; the result is still delivered.
REQ-011 pid_out SHALL hold its value between out_valid strobes.

Reset
REQ-012 rst_n=0 SHALL immediately force IDLE, busy=0, out_valid=0, pid_out=0, integ=0, e_prev=0, accumulator=0, regardless of the clock.
REQ-013 Reset asserted mid-computation SHALL discard it, with no out_valid after release.

Configuration
REQ-014 Macro PID_ANTI_WINDUP_EN defined: in ERR, the integ update SHALL be skipped when the previous pid_out was 255 and e>0, or when it was 0 and e<0.
REQ-015 Macro PID_ANTI_WINDUP_EN undefined: integ SHALL always update, limited only by sat12.

Structure
REQ-016 Package pid_pkg SHALL hold the width constants (8/6/9/10/12/20), the shift amount 4, the output limits 0/255 and the FSM state enum.
REQ-017 One sub-module, pid_mac, SHALL contain the single shared signed multiplier plus accumulator; there is one multiplier instance in total.

Verification
REQ-018 setpoint=100, feedback=80, K_p=8, K_i=K_d=0, single sample -> out_valid 5 cycles later, pid_out=10.
REQ-019 K_p=K_d=0, K_i=4, two samples with e=20 -> pid_out=5, then 10.
REQ-020 K_p=K_i=0, K_d=16, samples e=0 then e=10 -> pid_out=0, then 10.
REQ-021 Saturation cases:
- setpoint=255, feedback=0, K_p=63 -> pid_out=255.
- setpoint=0, feedback=200, K_p=8 -> pid_out=0.
REQ-022 sample_valid re-pulsed 2 cycles after acceptance -> ignored, exactly one out_valid.
REQ-023 Reset pulsed in MUL_I -> no out_valid, pid_out=0, busy=0.
REQ-024 With PID_ANTI_WINDUP_EN, K_i=63 and e=255 repeated -> integ stops growing once pid_out=255; first negative-e sample lowers pid_out below 255 immediately.

Source files
------------

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - widths, limits, state encoding and saturation helpers for pid_datapath
package pid_pkg;

    localparam int DATA_W    = 8;
    localparam int GAIN_W    = 6;
    localparam int ERR_W     = 9;
    localparam int DIFF_W    = 10;
    localparam int INTEG_W   = 12;
    localparam int ACC_W     = 20;
    localparam int OUT_SHIFT = 4;
    localparam int PROD_W    = GAIN_W + 1 + INTEG_W;

    localparam logic [DATA_W-1:0] OUT_MIN = 8'd0;
    localparam logic [DATA_W-1:0] OUT_MAX = 8'd255;

    localparam logic signed [INTEG_W:0] INTEG_SAT_MAX = 13'sd2047;
    localparam logic signed [INTEG_W:0] INTEG_SAT_MIN = -13'sd2048;
    localparam logic signed [ACC_W-1:0] ACC_OUT_MAX   = {{(ACC_W-DATA_W){1'b0}}, OUT_MAX};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_MUL_P,
        ST_MUL_I,
        ST_MUL_D,
        ST_OUT
    } pid_state_t;

    function automatic logic signed [INTEG_W-1:0] sat_integ(input logic signed [INTEG_W:0] v);
        if (v > INTEG_SAT_MAX)
            return INTEG_SAT_MAX[INTEG_W-1:0];
        else if (v < INTEG_SAT_MIN)
            return INTEG_SAT_MIN[INTEG_W-1:0];
        else
            return v[INTEG_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] clamp_out(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> OUT_SHIFT;
        if (sh[ACC_W-1])
            return OUT_MIN;
        else if (sh > ACC_OUT_MAX)
            return OUT_MAX;
        else
            return sh[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/pid_mac.sv
// rtl/pid_mac.sv - shared signed multiplier with 20-bit accumulator for the three PID terms
module pid_mac
    import pid_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic [GAIN_W-1:0]         i_gain,
    input  logic signed [INTEG_W-1:0] i_opnd,
    output logic signed [ACC_W-1:0]   o_acc
);

    logic signed [PROD_W-1:0] w_gain_x;
    logic signed [PROD_W-1:0] w_opnd_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  r_acc;

    // Gains are unsigned, so they enter the signed product zero-extended.
    assign w_gain_x = {{(PROD_W-GAIN_W){1'b0}}, i_gain};
    assign w_opnd_x = {{(PROD_W-INTEG_W){i_opnd[INTEG_W-1]}}, i_opnd};
    assign w_prod   = w_gain_x * w_opnd_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/pid_datapath.sv
// rtl/pid_datapath.sv - sequenced PID controller; PID_ANTI_WINDUP_EN enables integrator clamping
module pid_datapath
    import pid_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic [GAIN_W-1:0] K_p,
    input  logic [GAIN_W-1:0] K_i,
    input  logic [GAIN_W-1:0] K_d,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] pid_out
);

    pid_state_t r_state, w_next;
    logic                      w_accept;
    logic [DATA_W-1:0]         r_sp, r_fb;
    logic [GAIN_W-1:0]         r_kp, r_ki, r_kd;
    logic signed [ERR_W-1:0]   r_e;
    logic signed [DIFF_W-1:0]  r_d;
    logic signed [INTEG_W-1:0] r_integ;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_pid_out;

    logic signed [ERR_W-1:0]   w_e;
    logic signed [DIFF_W-1:0]  w_d;
    logic signed [INTEG_W:0]   w_integ_sum;
    logic                      w_hold_integ;
    logic                      w_mac_clr, w_mac_en;
    logic [GAIN_W-1:0]         w_mac_gain;
    logic signed [INTEG_W-1:0] w_mac_opnd;
    logic signed [ACC_W-1:0]   w_acc;

    // r_e keeps the current error and doubles as e_prev for the next sample.
    assign w_e         = {1'b0, r_sp} - {1'b0, r_fb};
    assign w_d         = {w_e[ERR_W-1], w_e} - {r_e[ERR_W-1], r_e};
    assign w_integ_sum = {r_integ[INTEG_W-1], r_integ} + {{(INTEG_W+1-ERR_W){w_e[ERR_W-1]}}, w_e};

`ifdef PID_ANTI_WINDUP_EN
    assign w_hold_integ = ((r_pid_out == OUT_MAX) && !w_e[ERR_W-1] && (w_e != '0)) ||
                          ((r_pid_out == OUT_MIN) &&  w_e[ERR_W-1]);
`else
    assign w_hold_integ = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sample_valid && ena) begin
                    w_accept = 1'b1;
                    w_next   = ST_ERR;
                end
            end
            ST_ERR:   w_next = ST_MUL_P;
            ST_MUL_P: w_next = ST_MUL_I;
            ST_MUL_I: w_next = ST_MUL_D;
            ST_MUL_D: w_next = ST_OUT;
            ST_OUT:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mac_clr  = (r_state == ST_ERR);
        w_mac_en   = 1'b0;
        w_mac_gain = '0;
        w_mac_opnd = '0;
        case (r_state)
            ST_MUL_P: begin
                w_mac_en   = 1'b1;
                w_mac_gain = r_kp;
                w_mac_opnd = {{(INTEG_W-ERR_W){r_e[ERR_W-1]}}, r_e};
            end
            ST_MUL_I: begin
                w_mac_en   = 1'b1;
                w_mac_gain = r_ki;
                w_mac_opnd = r_integ;
            end
            ST_MUL_D: begin
                w_mac_en   = 1'b1;
                w_mac_gain = r_kd;
                w_mac_opnd = {{(INTEG_W-DIFF_W){r_d[DIFF_W-1]}}, r_d};
            end
            default: ;
        endcase
    end

    pid_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_gain (w_mac_gain),
        .i_opnd (w_mac_opnd),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sp        <= '0;
            r_fb        <= '0;
            r_kp        <= '0;
            r_ki        <= '0;
            r_kd        <= '0;
            r_e         <= '0;
            r_d         <= '0;
            r_integ     <= '0;
            r_out_valid <= 1'b0;
            r_pid_out   <= '0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_sp <= setpoint;
                r_fb <= feedback;
                r_kp <= K_p;
                r_ki <= K_i;
                r_kd <= K_d;
            end
            if (r_state == ST_ERR) begin
                r_e <= w_e;
                r_d <= w_d;
                if (!w_hold_integ)
                    r_integ <= sat_integ(w_integ_sum);
            end
            // Result is registered on leaving OUT so it lands 5 edges after acceptance.
            if (r_state == ST_OUT) begin
                r_pid_out   <= clamp_out(w_acc);
                r_out_valid <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign pid_out   = r_pid_out;

endmodule

// File: tb/tb_pid_datapath.sv
// tb/tb_pid_datapath.sv - directed scoreboard bench for pid_datapath
module tb_pid_datapath;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] setpoint = '0;
    logic [7:0] feedback = '0;
    logic [5:0] K_p = '0;
    logic [5:0] K_i = '0;
    logic [5:0] K_d = '0;
    logic       busy;
    logic       out_valid;
    logic [7:0] pid_out;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_count = 0;
    int m_integ = 0, m_eprev = 0, m_prev_out = 0, m_last = 0;
    int mon_exp;
    int q[$];

    always #5 clk = ~clk;

    pid_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sample_valid (sample_valid),
        .setpoint     (setpoint),
        .feedback     (feedback),
        .K_p          (K_p),
        .K_i          (K_i),
        .K_d          (K_d),
        .busy         (busy),
        .out_valid    (out_valid),
        .pid_out      (pid_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_integ    = 0;
        m_eprev    = 0;
        m_prev_out = 0;
        q.delete();
    endfunction

    function automatic void model_push(input int sp, input int fb, input int kp, input int ki, input int kd);
        int e, d, acc, o;
        bit hold;
        e = sp - fb;
        d = e - m_eprev;
        hold = 1'b0;
`ifdef PID_ANTI_WINDUP_EN
        hold = (m_prev_out == 255 && e > 0) || (m_prev_out == 0 && e < 0);
`endif
        if (!hold) begin
            m_integ = m_integ + e;
            if (m_integ > 2047) m_integ = 2047;
            if (m_integ < -2048) m_integ = -2048;
        end
        m_eprev = e;
        acc = kp * e + ki * m_integ + kd * d;
        o = acc >>> 4;
        if (o < 0) o = 0;
        if (o > 255) o = 255;
        m_prev_out = o;
        q.push_back(o);
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_count++;
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                mon_exp = q.pop_front();
                chk("pid_out", pid_out, mon_exp);
                m_last = mon_exp;
            end
        end
    end

    task automatic send(input int sp, input int fb, input int kp, input int ki, input int kd,
                        input bit repulse, input bit drop_ena);
        int lat;
        int n0;
        @(negedge clk);
        setpoint = 8'(sp);
        feedback = 8'(fb);
        K_p = 6'(kp);
        K_i = 6'(ki);
        K_d = 6'(kd);
        ena = 1'b1;
        sample_valid = 1'b1;
        model_push(sp, fb, kp, ki, kd);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        K_p = 6'($urandom_range(63));
        K_i = 6'($urandom_range(63));
        K_d = 6'($urandom_range(63));
        setpoint = 8'($urandom_range(255));
        feedback = 8'($urandom_range(255));
        if (drop_ena) ena = 1'b0;
        chk("busy_accept", busy, 1);
        n0 = ov_count;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (repulse && c == 1) sample_valid = 1'b1;
            if (repulse && c == 2) sample_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
            chk("busy_inflight", busy, 1);
        end
        chk("latency", lat, 5);
        chk("busy_done", busy, 0);
        if (repulse) begin
            repeat (8) @(posedge clk);
            #1;
            chk("single_strobe", ov_count - n0, 1);
        end
        ena = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pid_out", pid_out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        #3;
        do_reset();
        ena = 1'b1;

        send(100, 80, 8, 0, 0, 0, 0);
        chk("p_only", pid_out, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("hold", pid_out, m_last);

        do_reset();
        send(120, 100, 0, 4, 0, 0, 0);
        chk("i_first", pid_out, 5);
        send(120, 100, 0, 4, 0, 0, 0);
        chk("i_second", pid_out, 10);

        do_reset();
        send(50, 50, 0, 0, 16, 0, 0);
        chk("d_first", pid_out, 0);
        send(60, 50, 0, 0, 16, 0, 0);
        chk("d_second", pid_out, 10);

        send(255, 0, 63, 0, 0, 0, 0);
        chk("sat_high", pid_out, 255);
        send(0, 200, 8, 0, 0, 0, 0);
        chk("sat_low", pid_out, 0);

        send(200, 90, 12, 2, 5, 0, 1);
        send(180, 60, 20, 3, 7, 1, 0);

        @(negedge clk);
        n0 = ov_count;
        ena = 1'b0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        ena = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("ena_low_ignored", ov_count - n0, 0);
        chk("ena_low_busy", busy, 0);

        @(negedge clk);
        setpoint = 8'd150;
        feedback = 8'd10;
        K_p = 6'd40;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n0 = ov_count;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pid_out", pid_out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_strobe", ov_count - n0, 0);
        chk("midrst_pid_out_after", pid_out, 0);

        send(100, 80, 8, 0, 0, 0, 0);
        chk("after_rst", pid_out, 10);

        do_reset();
        repeat (3) send(255, 0, 0, 63, 0, 0, 0);
        send(0, 255, 0, 63, 0, 0, 0);

        for (int k = 0; k < 6; k++)
            send($urandom_range(255), $urandom_range(255), $urandom_range(63),
                 $urandom_range(63), $urandom_range(63), 0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
